// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: load-use bubbles, memory-wait freeze, branch flush.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rd_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_stall_o,
    output logic        idex_bubble_o,
    output logic        exmem_stall_o,
    output logic        err_o,
    output logic [31:0] stall_cnt_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            br_pend_q, br_pend_d;
    logic            freeze, load_use, br;

    always_comb begin
        freeze = (state_q == MEM_WAIT && !mem_ack_i) ||
                 (state_q == RUN && mem_req_i && !mem_ack_i) ||
                 (state_q == ERR);
        load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
                   ((id_use_rs1_i && id_rs1_i == idex_rd_i) ||
                    (id_use_rs2_i && id_rs2_i == idex_rd_i));
        br = branch_taken_i || br_pend_q;

        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_stall_o = 1'b0;
        err_o         = (state_q == ERR);
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        br_pend_d     = br_pend_q;

        // A branch that cannot be flushed now is remembered until the pipeline moves.
        if (freeze) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_stall_o  = 1'b1;
            exmem_stall_o = 1'b1;
            if (branch_taken_i) br_pend_d = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            if (branch_taken_i) br_pend_d = 1'b1;
        end else if (br) begin
            ifid_flush_o = 1'b1;
            br_pend_d    = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_d = RUN;
                end else if (wcnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase

        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_stall_o  = 1'b0;
            idex_bubble_o = 1'b1;
            exmem_stall_o = 1'b0;
            err_o         = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            br_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            br_pend_q <= br_pend_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_o) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_cnt_q <= 32'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V core. Generates the write-enable, stall, bubble and flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, freezes the pipeline while a multi-cycle data-memory access is outstanding, and flushes IF/ID on taken branches. It is the producer side of the `stall_i` / bubble interface that the pipeline registers obey.

## Interface
Parameters:
- TIMEOUT_CYC, 16, maximum cycles spent in MEM_WAIT before declaring a bus error (≥2).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- id_rs1_i  in  5  rs1 address of the instruction in ID.
- id_rs2_i  in  5  rs2 address of the instruction in ID.
- id_use_rs1_i / id_use_rs2_i  in  1 each  ID instruction actually reads rs1 / rs2.
- idex_memread_i  in  1  MemRead of the instruction in EX (ID/EX output).
- idex_rd_i  in  5  RdAddr of the instruction in EX.
- branch_taken_i  in  1  taken-branch/jump pulse from ID.
- mem_req_i  in  1  MEM stage is issuing a load/store this cycle.
- mem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clears to NOP.
- idex_stall_o  out  1  ID/EX holds its contents.
- idex_bubble_o  out  1  ID/EX loads zero control signals.
- exmem_stall_o  out  1  EX/MEM and MEM/WB hold.
- err_o  out  1  sticky memory timeout.
- stall_cnt_o  out  32  stall-cycle counter (see Configuration).

## Operation
- States: RUN, MEM_WAIT, ERR. Internal: wait counter of width $clog2(TIMEOUT_CYC+1), br_pend flag.
- freeze = (state==MEM_WAIT && !mem_ack_i) || (state==RUN && mem_req_i && !mem_ack_i) || state==ERR.
- load_use = idex_memread_i && idex_rd_i!=0 && ((id_use_rs1_i && id_rs1_i==idex_rd_i) || (id_use_rs2_i && id_rs2_i==idex_rd_i)).
- br = branch_taken_i || br_pend.
- Priority: freeze > load_use > br.
- Freeze: pc_write_o=0, ifid_write_o=0, idex_stall_o=1, exmem_stall_o=1, idex_bubble_o=0, ifid_flush_o=0.
- Load-use (not frozen): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; all other stall/flush outputs 0. br_pend is set if branch_taken_i is high.
- Branch (not frozen, no load_use): pc_write_o=1, ifid_write_o=1, ifid_flush_o=1; br_pend is cleared.
- Otherwise: pc_write_o=1, ifid_write_o=1, all others 0.
- Transitions:
  - RUN→MEM_WAIT when mem_req_i && !mem_ack_i.
  - MEM_WAIT→RUN on mem_ack_i.
  - MEM_WAIT→ERR when the wait counter reaches TIMEOUT_CYC-1 without mem_ack_i.
  - ERR holds until rst_i.
- Wait counter: cleared on MEM_WAIT entry, increments each MEM_WAIT cycle.
- br_pend: set when branch_taken_i is high while freeze or load_use is active; cleared when the flush is issued.
- err_o=1 in ERR.

## Timing
- Hazard outputs are combinational from the current state and inputs; they are valid in the same cycle as the hazard.
- Load-use inserts exactly one bubble; the next cycle load_use is false because the bubble sits in EX.
- Zero-wait access (mem_req_i && mem_ack_i in the same cycle) causes no stall and no state change.
- Access acked after N wait cycles: freeze is asserted for N cycles, starting in the request cycle; the pipeline advances in the ack cycle.
- A branch arriving during a stall is flushed in the first cycle with no freeze and no load_use.
- While rst_i=1 (all outputs forced):
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, idex_stall_o=0, exmem_stall_o=0, err_o=0.
  - state←RUN, br_pend←0, wait counter←0, stall_cnt_o←0.
- Reset mid-MEM_WAIT or in ERR returns the block to RUN on the next edge.

## Configuration
- Macro HAZARD_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments by 1 on each non-reset cycle with pc_write_o=0.
  - 32-bit counter; wraps 0xFFFFFFFF→0.
- Undefined:
  - stall_cnt_o is tied to 0; no counter flops.
  - Port list is unchanged.

## Test plan
- Load-use: idex_memread_i=1, idex_rd_i=5, id_rs1_i=5, id_use_rs1_i=1 for one cycle → pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly 1 cycle.
- Load to x0: idex_rd_i=0, id_rs1_i=0, idex_memread_i=1 → no stall, pc_write_o=1.
- Memory wait: mem_req_i=1, mem_ack_i rises 3 cycles later → freeze outputs held for 3 cycles, released in the ack cycle, state RUN after; stall_cnt_o=3 with the macro defined, 0 without.
- Timeout with TIMEOUT_CYC=16: mem_req_i=1, mem_ack_i never asserted → err_o=1 after 16 cycles, freeze held permanently; rst_i pulse → err_o=0, RUN.
- Branch during load-use: branch_taken_i pulse in the load-use cycle → no flush that cycle; ifid_flush_o=1 in the next cycle.
- Reset during MEM_WAIT: rst_i high for 1 cycle → reset output values in that cycle, normal RUN outputs afterwards, stall_cnt_o=0.
